// File: rtl/btn_debounce.sv
// btn_debounce: multi-channel pushbutton conditioner.
// Each raw pin goes through a two-flop synchronizer and a per-channel
// stability counter. The block emits a debounced level plus registered,
// single-cycle press and release strobes. Channels are fully independent.
module btn_debounce #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 1000000,
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_press,
    output logic [WIDTH-1:0] btn_release
);

    // The counter's terminal value. Reaching it while the input still
    // disagrees with the level commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Synchronizer stages. sync0_q is only ever read by sync1_q.
    logic [WIDTH-1:0] sync0_q;
    logic [WIDTH-1:0] sync1_q;

    // Per-channel stability counters.
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Debounced level and strobes.
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] press_q;
    logic [WIDTH-1:0] press_d;
    logic [WIDTH-1:0] release_q;
    logic [WIDTH-1:0] release_d;

    // Combinational helpers.
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] update;

    // Two-flop synchronizer with no logic between the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= btn_in;
            sync1_q <= sync0_q;
        end
    end

    // Stability filter: count consecutive disagreeing cycles, commit on the last one.
    always_comb begin
        differ = sync1_q ^ level_q;
        update = '0;
        for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (differ[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    update[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        level_d   = (level_q & ~update) | (sync1_q & update);
        press_d   = update & sync1_q;
        release_d = update & ~sync1_q;
    end

    // Counter registers; any return to agreement restarts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < unsigned'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Level and strobe registers; strobes coincide with the level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: two instances (STABLE_CYCLES=4 and 1)
// checked against a sliding-window reference model plus directed timing checks.
module tb_btn_debounce;

    localparam int S0 = 4;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in0 = '0;
    logic [3:0] in1 = '0;
    logic [3:0] lvl0, prs0, rel0;
    logic [3:0] lvl1, prs1, rel1;

    int checks   = 0;
    int failures = 0;

    btn_debounce #(.WIDTH(4), .STABLE_CYCLES(S0)) dut (
        .clk(clk), .rst(rst), .btn_in(in0),
        .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0)
    );

    btn_debounce #(.WIDTH(4), .STABLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .btn_in(in1),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronized input is the raw input delayed by two
    // edges; the level flips when the last S synchronized samples all
    // disagree with it.
    logic [3:0] m_s0   [2];
    logic [3:0] m_hist [2][8];
    logic [3:0] m_lvl  [2];
    logic [3:0] m_prs  [2];
    logic [3:0] m_rel  [2];

    always @(posedge clk) begin
        logic [3:0] inj, cur, upd;
        int s;
        for (int j = 0; j < 2; j++) begin
            inj = (j == 0) ? in0 : in1;
            s   = (j == 0) ? S0 : S1;
            if (rst) begin
                m_s0[j] = '0;
                for (int k = 0; k < 8; k++) m_hist[j][k] = '0;
                m_lvl[j] = '0;
                m_prs[j] = '0;
                m_rel[j] = '0;
            end else begin
                cur = m_hist[j][0];
                for (int i = 0; i < 4; i++) begin
                    upd[i] = 1'b1;
                    for (int k = 0; k < s; k++)
                        if (m_hist[j][k][i] == m_lvl[j][i]) upd[i] = 1'b0;
                end
                m_prs[j] = upd & cur;
                m_rel[j] = upd & ~cur;
                m_lvl[j] = (m_lvl[j] & ~upd) | (cur & upd);
                for (int k = 7; k > 0; k--) m_hist[j][k] = m_hist[j][k-1];
                m_hist[j][0] = m_s0[j];
                m_s0[j] = inj;
            end
        end
    end

    task automatic test_reset();
        in0 = 4'hF;
        in1 = 4'h0;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0, lvl1, prs1, rel1} !== 24'h0) begin
                failures++;
                $display("FAIL reset_outputs: got %h want 000000", {lvl0, prs0, rel0, lvl1, prs1, rel1});
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0, lvl1, prs1, rel1} !== {m_lvl[0], m_prs[0], m_rel[0], m_lvl[1], m_prs[1], m_rel[1]}) begin
                failures++;
                $display("FAIL model_reset: edge %0d got %h want %h", e, {lvl0, prs0, rel0, lvl1, prs1, rel1},
                         {m_lvl[0], m_prs[0], m_rel[0], m_lvl[1], m_prs[1], m_rel[1]});
            end
            checks++;
            if (e < 6 && (lvl0 !== 4'h0 || prs0 !== 4'h0)) begin
                failures++;
                $display("FAIL held_early: edge %0d level %b press %b want 0000 0000", e, lvl0, prs0);
            end else if (e == 6 && (lvl0 !== 4'hF || prs0 !== 4'hF)) begin
                failures++;
                $display("FAIL held_press: edge %0d level %b press %b want 1111 1111", e, lvl0, prs0);
            end else if (e > 6 && (lvl0 !== 4'hF || prs0 !== 4'h0)) begin
                failures++;
                $display("FAIL held_after: edge %0d level %b press %b want 1111 0000", e, lvl0, prs0);
            end
        end
        in0 = 4'h0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0} !== {m_lvl[0], m_prs[0], m_rel[0]}) begin
                failures++;
                $display("FAIL model_unhold: got %h want %h", {lvl0, prs0, rel0}, {m_lvl[0], m_prs[0], m_rel[0]});
            end
        end
    endtask

    task automatic test_clean_press();
        in0 = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k < 5 && (lvl0 !== 4'b0000 || prs0 !== 4'b0000)) begin
                failures++;
                $display("FAIL press_early: k=%0d level %b press %b want 0000 0000", k, lvl0, prs0);
            end else if (k == 5 && (lvl0 !== 4'b0001 || prs0 !== 4'b0001)) begin
                failures++;
                $display("FAIL press_edge: k=%0d level %b press %b want 0001 0001", k, lvl0, prs0);
            end else if (k > 5 && (lvl0 !== 4'b0001 || prs0 !== 4'b0000 || rel0 !== 4'b0000)) begin
                failures++;
                $display("FAIL press_width: k=%0d level %b press %b rel %b want 0001 0000 0000", k, lvl0, prs0, rel0);
            end
        end
    endtask

    task automatic test_release();
        in0 = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (prs0 !== 4'b0000) begin
                failures++;
                $display("FAIL release_nopress: k=%0d press %b want 0000", k, prs0);
            end
            checks++;
            if (k < 5 && (lvl0 !== 4'b0001 || rel0 !== 4'b0000)) begin
                failures++;
                $display("FAIL release_early: k=%0d level %b rel %b want 0001 0000", k, lvl0, rel0);
            end else if (k == 5 && (lvl0 !== 4'b0000 || rel0 !== 4'b0001)) begin
                failures++;
                $display("FAIL release_edge: k=%0d level %b rel %b want 0000 0001", k, lvl0, rel0);
            end else if (k > 5 && (lvl0 !== 4'b0000 || rel0 !== 4'b0000)) begin
                failures++;
                $display("FAIL release_width: k=%0d level %b rel %b want 0000 0000", k, lvl0, rel0);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        seq = 5'b10101;
        for (int s = 0; s < 4; s++) begin
            in0[1] = seq[s];
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                checks++;
                if (prs0 !== 4'b0000 || rel0 !== 4'b0000 || lvl0 !== 4'b0000) begin
                    failures++;
                    $display("FAIL bounce_quiet: seg %0d level %b press %b rel %b want 0000 0000 0000", s, lvl0, prs0, rel0);
                end
            end
        end
        in0[1] = seq[4];
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k == 5 && (prs0 !== 4'b0010 || lvl0 !== 4'b0010)) begin
                failures++;
                $display("FAIL bounce_press: k=%0d level %b press %b want 0010 0010", k, lvl0, prs0);
            end else if (k != 5 && (prs0 !== 4'b0000 || rel0 !== 4'b0000)) begin
                failures++;
                $display("FAIL bounce_strobe: k=%0d press %b rel %b want 0000 0000", k, prs0, rel0);
            end
        end
        in0 = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0} !== {m_lvl[0], m_prs[0], m_rel[0]}) begin
                failures++;
                $display("FAIL model_bounce: got %h want %h", {lvl0, prs0, rel0}, {m_lvl[0], m_prs[0], m_rel[0]});
            end
        end
    endtask

    task automatic test_reset_mid();
        in0 = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (prs0 !== 4'b0000 || lvl0 !== 4'b0000) begin
                failures++;
                $display("FAIL midrst_pre: k=%0d level %b press %b want 0000 0000", k, lvl0, prs0);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({lvl0, prs0, rel0} !== 12'h000) begin
            failures++;
            $display("FAIL midrst_during: got %h want 000", {lvl0, prs0, rel0});
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            checks++;
            if (e == 6 && (prs0 !== 4'b0100 || lvl0 !== 4'b0100)) begin
                failures++;
                $display("FAIL midrst_press: edge %0d level %b press %b want 0100 0100", e, lvl0, prs0);
            end else if (e != 6 && prs0 !== 4'b0000) begin
                failures++;
                $display("FAIL midrst_strobe: edge %0d press %b want 0000", e, prs0);
            end
        end
    endtask

    task automatic test_simultaneous();
        in0 = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0} !== {m_lvl[0], m_prs[0], m_rel[0]}) begin
                failures++;
                $display("FAIL model_simul_setup: got %h want %h", {lvl0, prs0, rel0}, {m_lvl[0], m_prs[0], m_rel[0]});
            end
        end
        in0 = 4'b1100;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k == 5 && (prs0 !== 4'b1000 || rel0 !== 4'b0001 || lvl0 !== 4'b1100)) begin
                failures++;
                $display("FAIL simul_edge: level %b press %b rel %b want 1100 1000 0001", lvl0, prs0, rel0);
            end else if (k != 5 && (prs0 !== 4'b0000 || rel0 !== 4'b0000)) begin
                failures++;
                $display("FAIL simul_strobe: k=%0d press %b rel %b want 0000 0000", k, prs0, rel0);
            end
        end
        in0 = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0} !== {m_lvl[0], m_prs[0], m_rel[0]}) begin
                failures++;
                $display("FAIL model_simul_clear: got %h want %h", {lvl0, prs0, rel0}, {m_lvl[0], m_prs[0], m_rel[0]});
            end
        end
    endtask

    task automatic test_stable_one();
        in1 = 4'b0001;
        @(posedge clk); #1;
        in1 = 4'b0000;
        checks++;
        if ({lvl1, prs1, rel1} !== 12'h000) begin
            failures++;
            $display("FAIL s1_capture: got %h want 000", {lvl1, prs1, rel1});
        end
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k == 2 && {lvl1, prs1, rel1} !== {4'b0001, 4'b0001, 4'b0000}) begin
                failures++;
                $display("FAIL s1_press: got %h want 110", {lvl1, prs1, rel1});
            end else if (k == 3 && {lvl1, prs1, rel1} !== {4'b0000, 4'b0000, 4'b0001}) begin
                failures++;
                $display("FAIL s1_release: got %h want 001", {lvl1, prs1, rel1});
            end else if (k != 2 && k != 3 && {lvl1, prs1, rel1} !== 12'h000) begin
                failures++;
                $display("FAIL s1_idle: k=%0d got %h want 000", k, {lvl1, prs1, rel1});
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) in0[i] = ~in0[i];
                if ($urandom_range(0, 2) == 0) in1[i] = ~in1[i];
            end
            rst = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
            checks++;
            if ({lvl0, prs0, rel0, lvl1, prs1, rel1} !== {m_lvl[0], m_prs[0], m_rel[0], m_lvl[1], m_prs[1], m_rel[1]}) begin
                failures++;
                $display("FAIL model_random: cycle %0d got %h want %h", c, {lvl0, prs0, rel0, lvl1, prs1, rel1},
                         {m_lvl[0], m_prs[0], m_rel[0], m_lvl[1], m_prs[1], m_rel[1]});
            end
            checks++;
            if (((prs0 & rel0) | (prs1 & rel1)) !== 4'b0000) begin
                failures++;
                $display("FAIL strobe_exclusive: cycle %0d p0 %b r0 %b p1 %b r1 %b want disjoint", c, prs0, rel0, prs1, rel1);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_reset_mid();
        test_simultaneous();
        test_stable_one();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
